// File: rtl/monitoreo_pkg.sv
// Shared types and constants for the sensor monitoring path.
package monitoreo_pkg;

  localparam int TEMP_W = 10;

  // Highest temperature (tenths of a degree) accepted as a plausible reading.
  localparam logic [TEMP_W-1:0] TEMP_MAX_VALIDA = 10'd1000;

  typedef enum logic [1:0] {
    INACTIVO = 2'b00,
    ESPERA   = 2'b01
  } estado_planif_t;

  function automatic logic fuera_de_rango(input logic [TEMP_W-1:0] t);
    return t > TEMP_MAX_VALIDA;
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Round-robin arbiter: scans requests starting at the priority pointer and
// returns the first active one as a one-hot grant plus its index.
module arbitro_rr #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valida
);

  logic [IDX_W-1:0] w_pos;

  // Walk the channels from the pointer, wrapping around; first requester wins.
  always_comb begin
    o_grant  = '0;
    o_idx    = '0;
    o_valida = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_valida && i_req[w_pos]) begin
        o_valida       = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/planificador_sensores.sv
// Sensor scheduler: grants one temperature requester at a time (round-robin),
// forwards in-range samples to the monitor, holds the datapath for DWELL
// cycles per sample and flags channels that go unserved for too long.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   INACTIVO | idle, sampling req; any request is granted on this edge
//   ESPERA   | dwell on the last sample for DWELL cycles, req ignored
module planificador_sensores
  import monitoreo_pkg::*;
#(
  parameter int N_CANALES    = 4,
  parameter int DWELL        = 4,
  parameter int SILENCIO_MAX = 1000,
  localparam int IDX_W       = (N_CANALES > 1) ? $clog2(N_CANALES) : 1
) (
  input  logic                               clk,
  input  logic                               arst_n,
  input  logic [N_CANALES-1:0]               req,
  input  logic [N_CANALES-1:0][TEMP_W-1:0]   temp_canal,
  output logic [N_CANALES-1:0]               ack,
  output logic [TEMP_W-1:0]                  temp_salida,
  output logic                               temp_valida,
  output logic [IDX_W-1:0]                   canal_activo,
  output logic                               error_rango,
  output logic [N_CANALES-1:0]               falla_sensor,
  output logic [1:0]                         estado_planif
);

  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SIL_W   = $clog2(SILENCIO_MAX + 1);
  localparam logic [SIL_W-1:0]   SIL_TOPE   = SIL_W'(SILENCIO_MAX);
  localparam logic [DWELL_W-1:0] DWELL_INI  = DWELL_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]   IDX_ULTIMO = IDX_W'(N_CANALES - 1);

  estado_planif_t         r_estado, w_estado_sig;
  logic [DWELL_W-1:0]     r_dwell, w_dwell_sig;
  logic [IDX_W-1:0]       r_ptr;
  logic                   w_conceder;

  logic [N_CANALES-1:0]   w_grant;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_hay_req;
  logic [TEMP_W-1:0]      w_muestra;
  logic                   w_fuera;

  logic [N_CANALES-1:0]   r_ack;
  logic [TEMP_W-1:0]      r_temp_salida;
  logic                   r_temp_valida;
  logic                   r_error_rango;
  logic [IDX_W-1:0]       r_canal_activo;
  logic [SIL_W-1:0]       r_silencio [N_CANALES];

  arbitro_rr #(
    .N     (N_CANALES),
    .IDX_W (IDX_W)
  ) u_arbitro (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_valida (w_hay_req)
  );

  assign w_muestra = temp_canal[w_idx];
  assign w_fuera   = fuera_de_rango(w_muestra);

  // FSM state and dwell counter registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_estado <= INACTIVO;
      r_dwell  <= '0;
    end else begin
      r_estado <= w_estado_sig;
      r_dwell  <= w_dwell_sig;
    end
  end

  // Next-state logic: grant from idle, then count the dwell down to zero.
  always_comb begin
    w_estado_sig = r_estado;
    w_dwell_sig  = r_dwell;
    w_conceder   = 1'b0;
    case (r_estado)
      INACTIVO: begin
        if (w_hay_req) begin
          w_conceder   = 1'b1;
          w_estado_sig = ESPERA;
          w_dwell_sig  = DWELL_INI;
        end
      end
      ESPERA: begin
        if (r_dwell == '0) begin
          w_estado_sig = INACTIVO;
        end else begin
          w_dwell_sig = r_dwell - 1'b1;
        end
      end
      default: begin
        w_estado_sig = INACTIVO;
        w_dwell_sig  = '0;
      end
    endcase
  end

  // Grant-edge outputs: one-cycle pulses, sample capture and pointer advance.
  // Out-of-range samples still move the pointer and canal_activo but never
  // overwrite the last good sample.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ack          <= '0;
      r_temp_salida  <= '0;
      r_temp_valida  <= 1'b0;
      r_error_rango  <= 1'b0;
      r_canal_activo <= '0;
      r_ptr          <= '0;
    end else begin
      r_ack         <= w_conceder ? w_grant : '0;
      r_temp_valida <= w_conceder && !w_fuera;
      r_error_rango <= w_conceder && w_fuera;
      if (w_conceder) begin
        r_canal_activo <= w_idx;
        r_ptr          <= (w_idx == IDX_ULTIMO) ? '0 : w_idx + 1'b1;
        if (!w_fuera) begin
          r_temp_salida <= w_muestra;
        end
      end
    end
  end

  // Per-channel silence counters; a grant clears even on the saturating edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_CANALES; i++) begin
        r_silencio[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CANALES; i++) begin
        if (w_conceder && w_grant[i]) begin
          r_silencio[i] <= '0;
        end else if (r_silencio[i] != SIL_TOPE) begin
          r_silencio[i] <= r_silencio[i] + 1'b1;
        end
      end
    end
  end

  // Failure flag is simply "counter sitting at saturation".
  always_comb begin
    falla_sensor = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      falla_sensor[i] = (r_silencio[i] == SIL_TOPE);
    end
  end

  assign ack           = r_ack;
  assign temp_salida   = r_temp_salida;
  assign temp_valida   = r_temp_valida;
  assign error_rango   = r_error_rango;
  assign canal_activo  = r_canal_activo;
  assign estado_planif = r_estado;

endmodule

// File: doc/planificador_sensores.md
PLANIFICADOR_SENSORES -- requirements
Module: planificador_sensores

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and arst_n.
REQ-002 Parameter N_CANALES, default 4, SHALL set the number of sensor requesters.
REQ-003 Parameter DWELL, default 4, SHALL set the cycles the monitor datapath is held on one sample (DWELL >= 1).
REQ-004 Parameter SILENCIO_MAX, default 1000, SHALL set the cycles without a grant after which a channel is flagged as failed.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port arst_n  input  1  asynchronous, active-low reset.
REQ-007 Port req  input  N_CANALES  per-channel level request, held with stable data until ack.
REQ-008 Port temp_canal  input  N_CANALES x TEMP_W  per-channel temperature in tenths of a degree.
REQ-009 Port ack  output  N_CANALES  one-cycle grant/capture pulse, one-hot or zero.
REQ-010 Port temp_salida  output  TEMP_W  last accepted sample, drives the monitor's temp_entrada.
REQ-011 Port temp_valida  output  1  one-cycle pulse marking a new accepted sample.
REQ-012 Port canal_activo  output  clog2(N_CANALES)  index of the last granted channel.
REQ-013 Port error_rango  output  1  one-cycle pulse when a granted sample exceeds TEMP_MAX_VALIDA.
REQ-014 Port falla_sensor  output  N_CANALES  per-channel silence flag.
REQ-015 Port estado_planif  output  2  current FSM state encoding.

Function
REQ-016 The FSM SHALL have exactly two states: INACTIVO and ESPERA.
REQ-017 In INACTIVO with req == 0, the FSM SHALL remain in INACTIVO and all pulses SHALL stay low.
REQ-018 In INACTIVO with req != 0 at edge t, the FSM SHALL select a winner round-robin, capture temp_canal[winner], enter ESPERA and load the dwell counter with DWELL-1.
REQ-019 ack[winner] SHALL be high for exactly the cycle following edge t, giving a 1-cycle latency from req sample to ack.
REQ-020 Round-robin priority SHALL start at channel 0 after reset; after granting channel i, channel (i+1) mod N_CANALES SHALL have highest priority.
REQ-021 If the captured value is <= TEMP_MAX_VALIDA, temp_salida SHALL take the value and temp_valida SHALL pulse in the same cycle as ack.
REQ-022 If the captured value is > TEMP_MAX_VALIDA, temp_salida SHALL keep its old value, temp_valida SHALL stay low, and error_rango SHALL pulse in the same cycle as ack.
REQ-023 canal_activo SHALL update to the winner on every grant edge, including out-of-range grants.
REQ-024 ESPERA SHALL last exactly DWELL cycles and req SHALL be ignored throughout.
REQ-025 ESPERA SHALL then return to INACTIVO, so consecutive grants are spaced DWELL+1 cycles apart.
REQ-026 A channel that holds req high after its ack SHALL be re-served only when round-robin priority selects it.
REQ-027 Each channel SHALL have a silence counter that increments every cycle, saturates at SILENCIO_MAX, and clears to 0 on that channel's grant edge.
REQ-028 falla_sensor[i] SHALL be high while counter[i] == SILENCIO_MAX.
REQ-029 Where a grant and saturation of the same counter fall on the same edge, the clear SHALL take priority.

Reset
REQ-030 Asserting arst_n low SHALL asynchronously force the FSM to INACTIVO, the dwell counter and all silence counters to 0, and the priority pointer to 0.
REQ-031 Asserting arst_n low SHALL asynchronously force ack, temp_valida, error_rango and falla_sensor to 0, temp_salida to 0, and canal_activo to 0.
REQ-032 Reset asserted during ESPERA SHALL abort the dwell.
REQ-033 No grant SHALL occur before the first rising edge following reset deassertion.

Structure
REQ-034 TEMP_W (10), TEMP_MAX_VALIDA (1000) and typedef enum estado_planif_t SHALL reside in monitoreo_pkg.
REQ-035 Round-robin selection SHALL be a sub-module named arbitro_rr, taking req and the priority pointer as inputs and producing a one-hot grant and an index.

Verification
REQ-036 Single request: reset, then req=0001 with temp_canal[0]=250 -> ack=0001, temp_valida pulse and temp_salida=250 one cycle later; canal_activo=0.
REQ-037 Contention: req=1111 held with values 200/300/400/450 -> grants in order 0,1,2,3,0, spaced 5 cycles apart with DWELL=4.
REQ-038 Out of range: req=0100 with value 1010 -> ack=0100 and error_rango pulse; temp_valida stays low; temp_salida keeps the previous value.
REQ-039 Silence: SILENCIO_MAX=20 and only channel 0 requesting -> falla_sensor[3:1]=111 from cycle 20 on; falla_sensor[0] stays 0.
REQ-040 Reset mid-dwell: arst_n low 2 cycles after a grant -> all outputs 0 immediately; the next req=0010 is granted one cycle after its first sampling edge post-reset, and the priority pointer starts at 0.
